ps2_key_decoder: RTL and testbench

Upstream input stage for the Tetrix game logic. Receives raw PS/2 keyboard clock and data pins, which are asynchronous to the 50 MHz pixel clock. Deframes 11-bit PS/2 frames and strips E0/F0 prefixes. Emits one-cycle scan-code events and held-key levels for the four game controls to the playfield/colour generator that feeds the 800x600 VGA timing stage.

---
 rtl/tetrix_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 128 ++++++++++++
 rtl/ps2_key_decoder.sv | 112 +++++++++++
 tb/tb_ps2_key_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetrix_pkg.sv
// Shared constants for the Tetrix keyboard input path.
// Holds the PS/2 prefix bytes, the make codes of the four game controls
// (all extended codes) and the state encoding of the PS/2 frame receiver.
package tetrix_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_ROTATE = 8'h75;
    localparam logic [7:0] KEY_DROP   = 8'h72;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver.
// Synchronizes the raw PS/2 clock/data pins, detects falling edges of the
// PS/2 clock and deframes 11-bit frames (start, 8 data LSB-first, odd parity,
// stop). Aborts a frame that stalls for TIMEOUT_CYCLES clk cycles.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   kb_clk_i        raw PS/2 clock pin (asynchronous)
//   kb_data_i       raw PS/2 data pin (asynchronous)
//   byte_o          received byte, valid while byte_valid_o is high
//   byte_valid_o    one-cycle strobe, frame accepted
//   frame_err_o     one-cycle strobe, parity/stop/timeout error
module ps2_frame_rx
    import tetrix_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk_i,
    input  logic       kb_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   hist_q;

    rx_state_e   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] tmo_q, tmo_d;
    logic        byte_valid_q, byte_valid_d;
    logic        err_q, err_d;

    logic kb_clk_s, kb_data_s, fall;

    assign kb_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign kb_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall      = hist_q & ~kb_clk_s;

    // Synchronizers and edge history idle high, matching the released bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            hist_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb_data_i};
            hist_q      <= kb_clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        tmo_d        = (fall || state_q == RX_IDLE) ? 16'd0 : tmo_q + 16'd1;

        if (fall) begin
            unique case (state_q)
                RX_IDLE: begin
                    // A high start bit is a glitch; ignore it.
                    if (!kb_data_s) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {kb_data_s, shift_q[7:1]};
                    par_d     = par_q ^ kb_data_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    // par_q ends at 1 when data+parity has odd weight.
                    par_d   = par_q ^ kb_data_s;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (kb_data_s && par_q) byte_valid_d = 1'b1;
                    else                    err_d        = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && tmo_q == TMO_LIM) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
        end
    end

    // shift_q is frozen outside RX_DATA, so it is stable during the strobe.
    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder for the Tetrix game logic.
// Strips E0 (extended) and F0 (break) prefixes from the received byte stream,
// emits one-cycle scan-code events and keeps held levels for the four arrow
// keys used as game controls.
// Ports:
//   clk, rst         50 MHz clock, synchronous active-high reset
//   kbClk, kbData    raw PS/2 pins (asynchronous)
//   scan_code        last non-prefix byte (held until next scan_valid)
//   scan_valid       one-cycle strobe for scan_code/is_break/is_extended
//   is_break         F0 preceded scan_code
//   is_extended      E0 preceded scan_code
//   frame_err        one-cycle strobe on parity/stop/timeout error
//   key_left/right/rotate/drop  held levels of E0 6B/74/75/72
module ps2_key_decoder
    import tetrix_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbClk,
    input  logic       kbData,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_rotate,
    output logic       key_drop
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .kb_clk_i    (kbClk),
        .kb_data_i   (kbData),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

    logic       ext_q, brk_q;
    logic [7:0] scan_code_q;
    logic       scan_valid_q, is_break_q, is_extended_q;
    logic       key_left_q, key_right_q, key_rotate_q, key_drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            scan_code_q   <= '0;
            scan_valid_q  <= 1'b0;
            is_break_q    <= 1'b0;
            is_extended_q <= 1'b0;
            key_left_q    <= 1'b0;
            key_right_q   <= 1'b0;
            key_rotate_q  <= 1'b0;
            key_drop_q    <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == PS2_PREFIX_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PS2_PREFIX_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    scan_code_q   <= rx_byte;
                    is_extended_q <= ext_q;
                    is_break_q    <= brk_q;
                    scan_valid_q  <= 1'b1;
                    ext_q         <= 1'b0;
                    brk_q         <= 1'b0;
                    // Key levels move in the same cycle scan_valid rises.
                    if (ext_q) begin
                        unique case (rx_byte)
                            KEY_LEFT:   key_left_q   <= ~brk_q;
                            KEY_RIGHT:  key_right_q  <= ~brk_q;
                            KEY_ROTATE: key_rotate_q <= ~brk_q;
                            KEY_DROP:   key_drop_q   <= ~brk_q;
                            default: ;
                        endcase
                    end
                end
            end else if (rx_err) begin
                // An error orphans any pending prefix.
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign scan_code   = scan_code_q;
    assign scan_valid  = scan_valid_q;
    assign is_break    = is_break_q;
    assign is_extended = is_extended_q;
    assign frame_err   = rx_err;
    assign key_left    = key_left_q;
    assign key_right   = key_right_q;
    assign key_rotate  = key_rotate_q;
    assign key_drop    = key_drop_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: PS/2 frames are driven on the pins,
// a frame-level model predicts events, and a per-cycle compare process checks
// strobes, held outputs and key levels.
module tb_ps2_key_decoder;

    localparam int T = 300;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbClk = 1'b1;
    logic       kbData = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, is_break, is_extended, frame_err;
    logic       key_left, key_right, key_rotate, key_drop;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .kbClk(kbClk), .kbData(kbData),
        .scan_code(scan_code), .scan_valid(scan_valid), .is_break(is_break),
        .is_extended(is_extended), .frame_err(frame_err),
        .key_left(key_left), .key_right(key_right),
        .key_rotate(key_rotate), .key_drop(key_drop)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = scan event, 1 = stop/parity error, 2 = timeout error
    typedef struct {
        int         kind;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;
    ev_t q[$];

    int  vectors = 0, miscompares = 0;
    bit  chk_en = 1'b0;
    int  H = 8;
    int  last_fall = 0;

    // model state
    bit         p_ext = 0, p_brk = 0;     // pending prefixes
    logic [7:0] m_code = 0;
    bit         m_brk = 0, m_ext = 0;
    bit [3:0]   m_key = 0;                // {left,right,rotate,drop}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  lat;
        if (chk_en && !rst) begin
            check("valid_err_exclusive", {31'd0, scan_valid & frame_err}, 0);
            if (scan_valid || frame_err) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: scan_valid=%0b frame_err=%0b, none expected (cycle %0d)",
                             scan_valid, frame_err, cyc);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - last_fall;
                    if (e.kind == 0) begin
                        check("event_is_scan", {31'd0, scan_valid}, 1);
                        check("scan_latency", lat, S + 2);
                        m_code = e.code;
                        m_brk  = e.brk;
                        m_ext  = e.ext;
                        if (e.ext) begin
                            case (e.code)
                                8'h6B: m_key[3] = !e.brk;
                                8'h74: m_key[2] = !e.brk;
                                8'h75: m_key[1] = !e.brk;
                                8'h72: m_key[0] = !e.brk;
                                default: ;
                            endcase
                        end
                    end else begin
                        check("event_is_err", {31'd0, frame_err}, 1);
                        if (e.kind == 1) check("err_latency_in_window", {31'd0, (lat >= 1 && lat <= S + 2)}, 1);
                        else             check("timeout_in_window", {31'd0, (lat >= T && lat <= T + S + 2)}, 1);
                    end
                end
            end
            check("scan_code", scan_code, m_code);
            check("is_break", {31'd0, is_break}, m_brk);
            check("is_extended", {31'd0, is_extended}, m_ext);
            check("keys", {28'd0, key_left, key_right, key_rotate, key_drop}, m_key);
        end
    end

    task automatic drive_bit(input bit d);
        kbData = d;
        repeat (H / 2) @(posedge clk);
        #1 kbClk = 1'b0;
        last_fall = cyc;
        repeat (H) @(posedge clk);
        #1 kbClk = 1'b1;
        repeat (H - H / 2) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        repeat (8) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL event_missing: %0d expected events never seen (cycle %0d)", q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ev_t e;
        bit  par;
        par = ~(^b) ^ bad_par;
        e.code = b; e.brk = p_brk; e.ext = p_ext; e.kind = 0;
        if (bad_par || bad_stop) begin
            e.kind = 1; q.push_back(e);
            p_ext = 0; p_brk = 0;
        end else if (b == 8'hE0) begin
            p_ext = 1;
        end else if (b == 8'hF0) begin
            p_brk = 1;
        end else begin
            q.push_back(e);
            p_ext = 0; p_brk = 0;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(!bad_stop);
        kbData = 1'b1;
        drain(40);
    endtask

    task automatic send_partial(input int nbits);
        ev_t e;
        e.kind = 2; e.code = 0; e.brk = 0; e.ext = 0;
        q.push_back(e);
        p_ext = 0; p_brk = 0;
        drive_bit(1'b0);
        for (int i = 1; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
        kbData = 1'b1;
        drain(T + 60);
    endtask

    task automatic send_spurious();
        drive_bit(1'b1);
        repeat (20) @(posedge clk);
    endtask

    task automatic model_reset();
        p_ext = 0; p_brk = 0; m_code = 0; m_brk = 0; m_ext = 0; m_key = 0;
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, {19'd0, scan_code, scan_valid, is_break, is_extended,
                                  frame_err, key_left, key_right, key_rotate, key_drop}, 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         sel;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(posedge clk);

        // plain make code
        send_frame(8'h1C, 0, 0);
        @(negedge clk);
        check("lit_1C_code", scan_code, 8'h1C);
        check("lit_1C_brk_ext", {30'd0, is_break, is_extended}, 0);

        // extended press and release of left
        send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
        @(negedge clk);
        check("lit_left_press", {28'd0, key_left, key_right, key_rotate, key_drop}, 4'b1000);
        check("lit_left_ext", {31'd0, is_extended}, 1);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
        @(negedge clk);
        check("lit_left_release", {28'd0, key_left, key_right, key_rotate, key_drop}, 4'b0000);
        check("lit_release_brk", {31'd0, is_break}, 1);

        // F0 without E0 leaves key_left alone
        send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
        @(negedge clk);
        check("lit_nonext_break", {29'd0, is_break, is_extended, key_left}, 3'b101);

        // parity error, then prefix cleared by a stop error
        send_frame(8'h1C, 1, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'h55, 0, 1); send_frame(8'h6B, 0, 0);
        @(negedge clk);
        check("lit_ext_cleared", {31'd0, is_extended}, 0);

        // timeout after five bits, then a good frame
        send_partial(5);
        send_frame(8'h75, 0, 0);
        @(negedge clk);
        check("lit_after_timeout", scan_code, 8'h75);

        // spurious start, then a good frame
        send_spurious();
        send_frame(8'h72, 0, 0);
        @(negedge clk);
        check("lit_after_spurious", scan_code, 8'h72);

        // reset mid-frame (during data bit 4)
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("midframe_reset");
        @(posedge clk); #1 rst = 1'b0;
        kbData = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
        @(negedge clk);
        check("lit_right_after_reset", {28'd0, key_left, key_right, key_rotate, key_drop}, 4'b0100);

        // randomized traffic
        for (int n = 0; n < 90; n++) begin
            H   = $urandom_range(4, 12);
            sel = $urandom_range(0, 19);
            case ($urandom_range(0, 7))
                0, 1: b = 8'hE0;
                2:    b = 8'hF0;
                3:    b = 8'h6B;
                4:    b = 8'h74;
                5:    b = 8'h75;
                6:    b = 8'h72;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (sel == 0)      send_partial($urandom_range(1, 10));
            else if (sel == 1) send_spurious();
            else               send_frame(b, sel == 2, sel == 3);
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end

        repeat (20) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
